regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32-bit register bank among NUM_REQ requesters (ALU writeback, load unit, CSR/interrupt path). The bank is built from FlipFlopD-style 32-bit registers.
- Round-robin arbitration with a valid/ready handshake; the selected write is registered for one cycle before it reaches the bank.
- Datapath stall input freezes all grants.
- Writes to register 0 are granted (consumed) but never reach the bank.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- ZERO_DISCARD, 1, 1 = a grant to address 0 produces no wr_en.

Ports:
- clock, in, 1, system clock; all state changes on rising edge.
- reset, in, 1, synchronous, active-high reset.
- req_valid, in, NUM_REQ, bit i = requester i holds a pending write.
- req_addr, in, NUM_REQ*ADDR_W, packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data, in, NUM_REQ*DATA_W, packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready, out, NUM_REQ, one-hot grant, combinational. Handshake completes on a clock edge where valid & ready.
- wr_stall, in, 1, datapath stall; when high, no grant is issued.
- wr_en, out, 1, registered write enable to the bank.
- wr_addr, out, ADDR_W, registered write address.
- wr_data, out, DATA_W, registered write data.
- wr_src, out, 3, registered index of the granted requester.

Behaviour:
- Reset: on a rising edge with reset=1:
  - wr_en=0, wr_addr=0, wr_data=0, wr_src=0.
  - Round-robin pointer rr_ptr=0.
  - While reset is high, req_ready=0 regardless of inputs.
  - Reset overrides stall and any in-flight grant; the pending request stays un-acknowledged and the requester must keep it asserted.
- Arbitration (combinational, per cycle):
  - If reset=0, wr_stall=0 and req_valid≠0: g = first index with req_valid set, searching rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - req_ready = one-hot(g). Otherwise req_ready=0.
  - At most one req_ready bit is high in any cycle.
- Requester rules:
  - req_valid, req_addr and req_data stay stable until acknowledged.
  - Deasserting valid before acknowledge is illegal; the block's behaviour in that case is undefined but must not lock up.
- Write latency, one cycle. On the rising edge ending a cycle with grant g:
  - wr_addr = req_addr[g], wr_data = req_data[g], wr_src = g.
  - wr_en = 1, except wr_en = 0 when ZERO_DISCARD=1 and req_addr[g]=0 (the grant is still consumed).
  - rr_ptr = (g+1) mod NUM_REQ.
- Idle or stall cycle: on the next edge wr_en=0 and rr_ptr is unchanged. wr_addr, wr_data and wr_src hold their last values.
- Throughput: one write per cycle sustained. A requester can be re-granted back-to-back only if no other requester is valid.
- Fairness: a continuously valid requester is granted within NUM_REQ grant cycles.
- Pointer wrap: a grant to NUM_REQ-1 sets rr_ptr=0.
- Stall raised mid-stream: the write granted in the previous cycle still appears on wr_en. No new grant is issued while stall is high.
- No internal buffering beyond the single output register; no FIFO.

Test Plan:
- Reset check: drive reset=1 for 2 cycles with req_valid=3'b111, then release. Required: req_ready=0 and wr_en=0 during reset. On the first cycle after release, req_ready=3'b001 (rr_ptr=0).
- Round-robin: hold req_valid=3'b111 for 6 cycles with addr i+1 and data 83745+i for requester i. Required: grants 0,1,2,0,1,2. wr_en sequence after 1-cycle latency, wr_data 83745, 83746, 83747 repeating.
- Wrap and skip: with rr_ptr=2, drive req_valid=3'b011. Required: grant 0, then 1. rr_ptr goes 1, then 2.
- Stall: with req_valid=3'b010, pulse wr_stall high for 3 cycles. Required: req_ready=0 and wr_en=0 during stall. The grant occurs on the first unstalled cycle, and wr_data=12035 appears one cycle later.
- Zero register: requester 1 writes addr 0, data 123, with ZERO_DISCARD=1. Required: req_ready[1] pulses, wr_en stays 0, rr_ptr advances to 2.
- Reset mid-stream: assert reset in the cycle a grant to requester 2 (data 1927) is issued. Required: no wr_en on the next edge and rr_ptr=0. After release, requester 2 (still valid) is granted and wr_data=1927.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-bank write port among NUM_REQ requesters.
// The granted write is registered once before it reaches the bank; stall freezes all grants.
module regfile_write_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [2:0]                wr_src
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [2:0]         wr_src_q, wr_src_d;

  logic               grant_found_s;
  logic [2:0]         grant_idx_s;
  logic               grant_live_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               zero_hit_s;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return (addr == {ADDR_W{1'b0}});
  endfunction

  // Search from rr_ptr upward with wrap; walking k downward lets the nearest hit win.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      grant_idx_s   = req_valid[idx[IDX_W-1:0]] ? 3'(idx) : grant_idx_s;
      grant_found_s = grant_found_s | req_valid[idx[IDX_W-1:0]];
    end
  end

  // Constant-index mux of the granted requester's address and data.
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = (grant_idx_s == 3'(i)) ? req_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_data_s = (grant_idx_s == 3'(i)) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
    end
  end

  // Grant qualification and one-hot ready.
  always_comb begin
    grant_live_s = ~reset & ~wr_stall & grant_found_s;
    if (grant_live_s) begin
      req_ready = ONE_HOT_0 << grant_idx_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Next state of the output register and pointer; idle cycles hold address, data and source.
  always_comb begin
    zero_hit_s = ZERO_DISCARD & is_zero_addr(sel_addr_s);
    wr_en_d    = grant_live_s & ~zero_hit_s;
    if (grant_live_s) begin
      wr_addr_d = sel_addr_s;
      wr_data_d = sel_data_s;
      wr_src_d  = grant_idx_s;
      rr_ptr_d  = (grant_idx_s == LAST_IDX) ? 3'd0 : grant_idx_s + 3'd1;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_src_d  = wr_src_q;
      rr_ptr_d  = rr_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q  <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
      wr_src_q  <= 3'd0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

endmodule
